// File: rtl/lift_ctrl_n.sv
// N-floor collective (SCAN) lift controller: hall calls are latched into per-floor
// up/down bitmaps and served in the current travel direction before reversing.
module lift_ctrl_n #(
  parameter int FLOORS      = 4,
  parameter int FW          = ($clog2(FLOORS) < 1) ? 1 : $clog2(FLOORS),
  parameter int MOVE_CYCLES = 4,
  parameter int DOOR_CYCLES = 3,
  parameter int CW          = $clog2(((MOVE_CYCLES > DOOR_CYCLES) ? MOVE_CYCLES : DOOR_CYCLES) + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req_valid,
  input  logic [FW-1:0] req_floor,
  input  logic          req_up,
  output logic          req_err,
  output logic [FW-1:0] cur_floor,
  output logic [1:0]    dout,
  output logic          door_open,
  output logic          arrive,
  output logic          done
);
  localparam int LAST = FLOORS - 1;

  typedef enum logic [1:0] {S_IDLE, S_MOVE, S_DOOR} state_t;

  state_t            state_reg, state_next;
  logic [FLOORS-1:0] up_reg, up_next, dn_reg, dn_next, pend_any;
  logic              dir_reg, dir_next;
  logic [FW-1:0]     floor_reg, floor_next, nf;
  logic [CW-1:0]     cnt_reg, cnt_next;
  logic [1:0]        dout_next;
  logic              door_next, arrive_next, done_next;
  logic              call_bad, call_ok, call_here, fwd, stop;

  // Any pending floor strictly beyond f in the given direction.
  function automatic logic ahead(input logic [FLOORS-1:0] bits, input logic [FW-1:0] f,
                                 input logic up);
    logic r;
    r = 1'b0;
    for (int i = 0; i < FLOORS; i++) begin
      if (up ? (i > int'(f)) : (i < int'(f))) r = r | bits[i];
    end
    return r;
  endfunction

  assign call_bad  = req_valid && ((int'(req_floor) > LAST) ||
                                   (req_up && int'(req_floor) == LAST) ||
                                   (!req_up && req_floor == '0));
  assign call_ok   = req_valid && !call_bad;
  assign call_here = call_ok && (req_floor == floor_reg);
  assign pend_any  = up_reg | dn_reg;
  assign nf        = dir_reg ? floor_reg + FW'(1) : floor_reg - FW'(1);
  assign fwd       = ahead(pend_any, nf, dir_reg);
  assign stop      = (dir_reg ? up_reg[nf] : dn_reg[nf]) || (pend_any[nf] && !fwd) ||
                     (nf == '0) || (int'(nf) == LAST);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg <= S_IDLE;
      up_reg    <= '0;
      dn_reg    <= '0;
      dir_reg   <= 1'b1;
      floor_reg <= '0;
      cnt_reg   <= '0;
      dout      <= 2'b10;
      door_open <= 1'b0;
      arrive    <= 1'b0;
      req_err   <= 1'b0;
      done      <= 1'b1;
    end else begin
      state_reg <= state_next;
      up_reg    <= up_next;
      dn_reg    <= dn_next;
      dir_reg   <= dir_next;
      floor_reg <= floor_next;
      cnt_reg   <= cnt_next;
      dout      <= dout_next;
      door_open <= door_next;
      arrive    <= arrive_next;
      req_err   <= call_bad;
      done      <= done_next;
    end
  end

  assign cur_floor = floor_reg;

  always_comb begin
    state_next = state_reg;
    up_next    = up_reg;
    dn_next    = dn_reg;
    dir_next   = dir_reg;
    floor_next = floor_reg;
    cnt_next   = cnt_reg;
    // New calls are applied first so that a clear on the same edge wins.
    if (call_ok && !(call_here && state_reg != S_MOVE)) begin
      for (int i = 0; i < FLOORS; i++) begin
        if (int'(req_floor) == i) begin
          if (req_up) up_next[i] = 1'b1;
          else        dn_next[i] = 1'b1;
        end
      end
    end
    case (state_reg)
      S_IDLE: begin
        if (pend_any[floor_reg] || call_here) begin
          state_next         = S_DOOR;
          cnt_next           = '0;
          up_next[floor_reg] = 1'b0;
          dn_next[floor_reg] = 1'b0;
        end else if (ahead(pend_any, floor_reg, dir_reg)) begin
          state_next = S_MOVE;
          cnt_next   = '0;
        end else if (ahead(pend_any, floor_reg, !dir_reg)) begin
          state_next = S_MOVE;
          dir_next   = !dir_reg;
          cnt_next   = '0;
        end
      end
      S_MOVE: begin
        if (cnt_reg == CW'(MOVE_CYCLES - 1)) begin
          floor_next = nf;
          cnt_next   = '0;
          if (stop) begin
            state_next = S_DOOR;
            if (!fwd || dir_reg)  up_next[nf] = 1'b0;
            if (!fwd || !dir_reg) dn_next[nf] = 1'b0;
          end
        end else begin
          cnt_next = cnt_reg + CW'(1);
        end
      end
      S_DOOR: begin
        if (call_here) begin
          cnt_next = '0;
        end else if (cnt_reg == CW'(DOOR_CYCLES - 1)) begin
          state_next = S_IDLE;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg + CW'(1);
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_comb begin
    dout_next   = 2'b10;
    if (state_next == S_MOVE) dout_next = dir_next ? 2'b00 : 2'b01;
    door_next   = (state_next == S_DOOR);
    arrive_next = (state_next == S_DOOR) && (state_reg != S_DOOR);
    done_next   = (state_next == S_IDLE) && ((up_next | dn_next) == '0);
  end
endmodule

// File: tb/tb_lift_ctrl_n.sv
// Bench for lift_ctrl_n: directed scenarios plus random hall calls, all checked each
// cycle against a countdown-based behavioural model of the collective policy.
module tb_lift_ctrl_n;
  localparam int FLOORS = 5;
  localparam int MOVE_C = 2;
  localparam int DOOR_C = 3;
  localparam int FW     = 3;
  localparam int LAST   = FLOORS - 1;
  localparam int M_IDLE = 0, M_MOVING = 1, M_DOOR = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req_valid = 1'b0;
  logic [FW-1:0] req_floor = '0;
  logic          req_up = 1'b0;
  logic          req_err;
  logic [FW-1:0] cur_floor;
  logic [1:0]    dout;
  logic          door_open, arrive, done;

  lift_ctrl_n #(.FLOORS(FLOORS), .MOVE_CYCLES(MOVE_C), .DOOR_CYCLES(DOOR_C)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_floor(req_floor),
    .req_up(req_up), .req_err(req_err), .cur_floor(cur_floor), .dout(dout),
    .door_open(door_open), .arrive(arrive), .done(done)
  );

  always #5 clk = ~clk;

  int m_floor, m_dir, m_mode, m_left;
  bit up_p [FLOORS];
  bit dn_p [FLOORS];
  bit e_err, e_arrive;

  int n_vec = 0, n_fail = 0;
  int cnt_up, cnt_dn, cnt_door, cnt_arr, cnt_err;
  int arr_log [$];

  function automatic bit beyond(input bit a [FLOORS], input bit b [FLOORS], input int fl,
                                input int d);
    bit r;
    r = 1'b0;
    for (int i = 0; i < FLOORS; i++) if ((i - fl) * d > 0 && (a[i] || b[i])) r = 1'b1;
    return r;
  endfunction

  function automatic bit none_pending();
    bit r;
    r = 1'b1;
    for (int i = 0; i < FLOORS; i++) if (up_p[i] || dn_p[i]) r = 1'b0;
    return r;
  endfunction

  task automatic model_step(input bit rst, input bit v, input int f, input bit up);
    bit ou [FLOORS];
    bit od [FLOORS];
    bit bad, ok, here, fwd, want;
    int g;
    if (!rst) begin
      m_floor = 0; m_dir = 1; m_mode = M_IDLE; m_left = 0;
      for (int i = 0; i < FLOORS; i++) begin up_p[i] = 1'b0; dn_p[i] = 1'b0; end
      e_err = 1'b0; e_arrive = 1'b0;
      return;
    end
    e_arrive = 1'b0;
    bad   = v && (f > LAST || (up && f == LAST) || (!up && f == 0));
    e_err = bad;
    ok    = v && !bad;
    here  = ok && (f == m_floor);
    ou = up_p;
    od = dn_p;
    if (ok && !(here && m_mode != M_MOVING)) begin
      if (up) up_p[f] = 1'b1;
      else    dn_p[f] = 1'b1;
    end
    case (m_mode)
      M_IDLE: begin
        if (ou[m_floor] || od[m_floor] || here) begin
          m_mode = M_DOOR; m_left = DOOR_C; e_arrive = 1'b1;
          up_p[m_floor] = 1'b0; dn_p[m_floor] = 1'b0;
        end else if (beyond(ou, od, m_floor, m_dir)) begin
          m_mode = M_MOVING; m_left = MOVE_C;
        end else if (beyond(ou, od, m_floor, -m_dir)) begin
          m_dir = -m_dir; m_mode = M_MOVING; m_left = MOVE_C;
        end
      end
      M_MOVING: begin
        m_left--;
        if (m_left == 0) begin
          m_floor += m_dir;
          g    = m_floor;
          fwd  = beyond(ou, od, g, m_dir);
          want = (m_dir > 0) ? ou[g] : od[g];
          if (want || ((ou[g] || od[g]) && !fwd) || g == 0 || g == LAST) begin
            m_mode = M_DOOR; m_left = DOOR_C; e_arrive = 1'b1;
            if (!fwd) begin up_p[g] = 1'b0; dn_p[g] = 1'b0; end
            else if (m_dir > 0) up_p[g] = 1'b0;
            else dn_p[g] = 1'b0;
          end else begin
            m_left = MOVE_C;
          end
        end
      end
      default: begin
        if (here) m_left = DOOR_C;
        else begin
          m_left--;
          if (m_left == 0) m_mode = M_IDLE;
        end
      end
    endcase
  endtask

  task automatic chk(input string name, input int act, input int exp);
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_all();
    int e_dout;
    e_dout = (m_mode == M_MOVING) ? ((m_dir > 0) ? 0 : 1) : 2;
    chk("dout", int'(dout), e_dout);
    chk("cur_floor", int'(cur_floor), m_floor);
    chk("door_open", int'(door_open), int'(m_mode == M_DOOR));
    chk("arrive", int'(arrive), int'(e_arrive));
    chk("req_err", int'(req_err), int'(e_err));
    chk("done", int'(done), int'(m_mode == M_IDLE && none_pending()));
  endtask

  task automatic clr_counts();
    cnt_up = 0; cnt_dn = 0; cnt_door = 0; cnt_arr = 0; cnt_err = 0;
    arr_log.delete();
  endtask

  task automatic tick(input bit v, input int f, input bit up);
    req_valid = v;
    req_floor = f[FW-1:0];
    req_up    = up;
    @(posedge clk);
    model_step(rst_n, v, f, up);
    #1;
    check_all();
    n_vec++;
    if (dout == 2'b00) cnt_up++;
    if (dout == 2'b01) cnt_dn++;
    if (door_open) cnt_door++;
    if (req_err) cnt_err++;
    if (arrive) begin cnt_arr++; arr_log.push_back(int'(cur_floor)); end
    req_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, 0, 1'b0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    idle(2);
    rst_n = 1'b1;
  endtask

  initial begin
    clr_counts();
    do_reset();
    chk("lit_rst_dout", int'(dout), 2);
    chk("lit_rst_floor", int'(cur_floor), 0);
    chk("lit_rst_door", int'(door_open), 0);
    chk("lit_rst_done", int'(done), 1);
    chk("lit_rst_err", int'(req_err), 0);

    // single call floor 2 up: 2 floors x 2 cycles of UP, one arrival, 3 door cycles
    clr_counts();
    tick(1'b1, 2, 1'b1);
    idle(12);
    chk("lit_single_up_cycles", cnt_up, 4);
    chk("lit_single_arrive", cnt_arr, 1);
    chk("lit_single_door_cycles", cnt_door, 3);
    chk("lit_single_floor", int'(cur_floor), 2);
    chk("lit_single_done", int'(done), 1);

    // collective order: 3-down then 1-up, served as stop@1 then stop@3
    do_reset();
    clr_counts();
    tick(1'b1, 3, 1'b0);
    tick(1'b1, 1, 1'b1);
    idle(22);
    chk("lit_coll_arrivals", cnt_arr, 2);
    chk("lit_coll_first", (arr_log.size() > 0) ? arr_log[0] : -1, 1);
    chk("lit_coll_second", (arr_log.size() > 1) ? arr_log[1] : -1, 3);
    chk("lit_coll_floor", int'(cur_floor), 3);

    // reversal from floor 3 to a 0-up call
    clr_counts();
    tick(1'b1, 0, 1'b1);
    idle(16);
    chk("lit_rev_down_cycles", cnt_dn, 6);
    chk("lit_rev_arrive", cnt_arr, 1);
    chk("lit_rev_floor", int'(cur_floor), 0);

    // rejected calls
    clr_counts();
    tick(1'b1, 4, 1'b1);
    tick(1'b1, 0, 1'b0);
    tick(1'b1, 6, 1'b1);
    tick(1'b1, 7, 1'b0);
    idle(4);
    chk("lit_rej_errs", cnt_err, 4);
    chk("lit_rej_moves", cnt_up + cnt_dn, 0);
    chk("lit_rej_done", int'(done), 1);

    // same-floor calls at floor 2, then reset mid-move
    tick(1'b1, 2, 1'b1);
    idle(12);
    tick(1'b1, 2, 1'b0);
    chk("lit_same_door_now", int'(door_open), 1);
    idle(1);
    clr_counts();
    tick(1'b1, 2, 1'b1);
    idle(5);
    chk("lit_same_door_held", cnt_door, 3);
    chk("lit_same_no_arrive", cnt_arr, 0);
    chk("lit_same_done", int'(done), 1);
    tick(1'b1, 4, 1'b0);
    idle(3);
    chk("lit_mid_moving", int'(dout), 0);
    rst_n = 1'b0;
    idle(1);
    rst_n = 1'b1;
    chk("lit_mid_rst_floor", int'(cur_floor), 0);
    chk("lit_mid_rst_dout", int'(dout), 2);
    chk("lit_mid_rst_done", int'(done), 1);
    clr_counts();
    idle(5);
    chk("lit_mid_rst_no_move", cnt_up + cnt_dn, 0);

    // random hall calls with occasional reset
    for (int i = 0; i < 4000; i++) begin
      rst_n = ($urandom_range(0, 999) != 0);
      if ($urandom_range(0, 5) == 0)
        tick(1'b1, int'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
      else
        tick(1'b0, 0, 1'b0);
    end
    rst_n = 1'b1;
    idle(40);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end
endmodule
